stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter MIN_MAX, default 59, giving the largest minutes value before wrap (legal range 1..99).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port tick_1hz, input, 1, a one-cycle count-enable pulse at 1 Hz.
REQ-005 The block SHALL have port tick_adj, input, 1, a one-cycle adjust-step pulse at about 2 Hz.
REQ-006 The block SHALL have port pause_btn, input, 1, a debounced level whose rising edge toggles run/pause.
REQ-007 The block SHALL have port clr_btn, input, 1, a debounced level whose rising edge clears the time.
REQ-008 The block SHALL have port adj, input, 1, a level that selects adjust mode while high.
REQ-009 The block SHALL have port sel, input, 1, the adjust field select: 0 = minutes, 1 = seconds.
REQ-010 The block SHALL have ports min_l, min_r, sec_l, sec_r, output, 5 each, registered BCD digits 0..9 (bit 4 always 0).
REQ-011 The block SHALL have port adj_out, output, 1, a registered copy of the adjust-mode flag for the display blinker.
REQ-012 The block SHALL have port adj_sel, output, 3, a registered digit index to blink: 3 = minutes tens, 1 = seconds tens, 4 = none.
REQ-013 The block SHALL have port running, output, 1, high only in state RUN.

Function
REQ-014 The FSM SHALL have three states, PAUSED, RUN and ADJUST, encoded in 2 bits; the unused code SHALL return to PAUSED on the next clock.
REQ-015 Each button SHALL have a rising-edge detector: edge = btn & ~btn_q, where btn_q is registered every cycle.
REQ-016 Event priority per cycle SHALL be rst > clr edge > adj > pause edge > tick.
REQ-017 A clr edge in any state SHALL zero all four digits on that edge; in RUN it SHALL also move the FSM to PAUSED; in ADJUST the FSM SHALL stay in ADJUST.
REQ-018 adj high in PAUSED or RUN SHALL enter ADJUST on the next edge; adj low in ADJUST SHALL return to PAUSED, never to RUN.
REQ-019 A pause edge SHALL move PAUSED to RUN and RUN to PAUSED; a pause edge in ADJUST SHALL be ignored and not remembered.
REQ-020 In RUN, each tick_1hz SHALL advance the time by one second, registered and visible on the following cycle.
REQ-021 The seconds count SHALL carry sec_r 9->0 into sec_l, and sec_l 5 with sec_r 9 (59) into the minutes digits.
REQ-022 The minutes count SHALL carry min_r 9->0 into min_l; at MIN_MAX:59 the next tick SHALL give 00:00.
REQ-023 tick_1hz SHALL be ignored in PAUSED and ADJUST.
REQ-024 In ADJUST, each tick_adj SHALL increment the selected field by 1: seconds wrap 59->00 with no carry into minutes; minutes wrap MIN_MAX->00.
REQ-025 tick_adj SHALL be ignored outside ADJUST.
REQ-026 A sel change in ADJUST SHALL take effect on the next tick_adj.
REQ-027 adj_sel SHALL be 3 when ADJUST and sel=0, 1 when ADJUST and sel=1, and 4 otherwise.
REQ-028 adj_out SHALL equal (state == ADJUST), registered.
REQ-029 All digit outputs SHALL remain valid BCD at all times; no invalid digit value SHALL ever be reached.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL set: state PAUSED, all digits 0, running 0, adj_out 0, adj_sel 4.
REQ-031 While rst=1 at a clock edge, the block SHALL set btn_q for both buttons to 1, so a button held through reset does not fire on release of rst.
REQ-032 rst asserted mid-count or mid-adjust SHALL discard the operation in progress; no tick or edge in the rst cycle SHALL take effect.

Verification
REQ-033 The bench SHALL check: reset, then pause edge, then 61 tick_1hz -> 01:01, running=1.
REQ-034 The bench SHALL check: preload 59:59 in RUN, one tick_1hz -> 00:00 on the next cycle (MIN_MAX=59).
REQ-035 The bench SHALL check: RUN at 00:05, clr edge and tick_1hz in the same cycle -> 00:00, state PAUSED, running=0.
REQ-036 The bench SHALL check: adj=1, sel=1 at 00:58, then 3 tick_adj -> 00:01, adj_sel=1, adj_out=1; then adj=0 -> PAUSED, adj_sel=4.
REQ-037 The bench SHALL check: in ADJUST, pause edge plus 10 tick_1hz -> no change; after adj=0, running=0.
REQ-038 The bench SHALL check: pause_btn held high across reset -> no RUN entry until pause_btn falls and rises again.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: PAUSED/RUN/ADJUST FSM driving four BCD digits as MM:SS.
// Minutes wrap after MIN_MAX; seconds wrap after 59.
module stopwatch_ctrl #(
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_adj,
  input  logic       pause_btn,
  input  logic       clr_btn,
  input  logic       adj,
  input  logic       sel,
  output logic [4:0] min_l,
  output logic [4:0] min_r,
  output logic [4:0] sec_l,
  output logic [4:0] sec_r,
  output logic       adj_out,
  output logic [2:0] adj_sel,
  output logic       running
);

  localparam logic [3:0] MinMaxTens = 4'(MIN_MAX / 10);
  localparam logic [3:0] MinMaxOnes = 4'(MIN_MAX % 10);

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_stateNext;
  logic       r_pauseQ;
  logic       r_clrQ;
  logic [3:0] r_minL, r_minR, r_secL, r_secR;
  logic [3:0] w_minLNext, w_minRNext, w_secLNext, w_secRNext;
  logic [3:0] w_minLInc, w_minRInc, w_secLInc, w_secRInc;
  logic       w_secWrap;
  logic       w_pauseEdge;
  logic       w_clrEdge;

  assign w_pauseEdge = pause_btn & ~r_pauseQ;
  assign w_clrEdge   = clr_btn & ~r_clrQ;

  // Incremented copies of both fields, each already wrapped within its own range.
  always_comb begin
    w_secRInc = r_secR + 4'd1;
    w_secLInc = r_secL;
    w_secWrap = 1'b0;
    if (r_secR == 4'd9) begin
      w_secRInc = 4'd0;
      if (r_secL == 4'd5) begin
        w_secLInc = 4'd0;
        w_secWrap = 1'b1;
      end else begin
        w_secLInc = r_secL + 4'd1;
      end
    end
    w_minRInc = r_minR + 4'd1;
    w_minLInc = r_minL;
    if (r_minL == MinMaxTens && r_minR == MinMaxOnes) begin
      w_minRInc = 4'd0;
      w_minLInc = 4'd0;
    end else if (r_minR == 4'd9) begin
      w_minRInc = 4'd0;
      w_minLInc = r_minL + 4'd1;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_minLNext  = r_minL;
    w_minRNext  = r_minR;
    w_secLNext  = r_secL;
    w_secRNext  = r_secR;
    case (r_state)
      PAUSED, RUN, ADJUST: begin
        if (w_clrEdge) begin
          w_minLNext = 4'd0;
          w_minRNext = 4'd0;
          w_secLNext = 4'd0;
          w_secRNext = 4'd0;
          if (r_state == RUN) w_stateNext = PAUSED;
        end else if (adj) begin
          if (r_state != ADJUST) begin
            w_stateNext = ADJUST;
          end else if (tick_adj) begin
            if (sel) begin
              w_secLNext = w_secLInc;
              w_secRNext = w_secRInc;
            end else begin
              w_minLNext = w_minLInc;
              w_minRNext = w_minRInc;
            end
          end
        end else if (r_state == ADJUST) begin
          w_stateNext = PAUSED;
        end else if (w_pauseEdge) begin
          w_stateNext = (r_state == RUN) ? PAUSED : RUN;
        end else if (tick_1hz && r_state == RUN) begin
          w_secLNext = w_secLInc;
          w_secRNext = w_secRInc;
          if (w_secWrap) begin
            w_minLNext = w_minLInc;
            w_minRNext = w_minRInc;
          end
        end
      end
      default: begin
        w_stateNext = PAUSED;
        if (w_clrEdge) begin
          w_minLNext = 4'd0;
          w_minRNext = 4'd0;
          w_secLNext = 4'd0;
          w_secRNext = 4'd0;
        end
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= PAUSED;
      r_minL   <= 4'd0;
      r_minR   <= 4'd0;
      r_secL   <= 4'd0;
      r_secR   <= 4'd0;
      r_pauseQ <= 1'b1;
      r_clrQ   <= 1'b1;
      running  <= 1'b0;
      adj_out  <= 1'b0;
      adj_sel  <= 3'd4;
    end else begin
      r_state  <= w_stateNext;
      r_minL   <= w_minLNext;
      r_minR   <= w_minRNext;
      r_secL   <= w_secLNext;
      r_secR   <= w_secRNext;
      r_pauseQ <= pause_btn;
      r_clrQ   <= clr_btn;
      running  <= (w_stateNext == RUN);
      adj_out  <= (w_stateNext == ADJUST);
      adj_sel  <= (w_stateNext == ADJUST) ? (sel ? 3'd1 : 3'd3) : 3'd4;
    end
  end

  assign min_l = {1'b0, r_minL};
  assign min_r = {1'b0, r_minR};
  assign sec_l = {1'b0, r_secL};
  assign sec_r = {1'b0, r_secR};

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a constant vector table, hand-written
// corner sequences, then random stimulus against a minutes/seconds reference model.
module tb_stopwatch_ctrl;

  localparam int MIN_MAX = 59;

  logic       clk;
  logic       rst, tick_1hz, tick_adj, pause_btn, clr_btn, adj, sel;
  logic [4:0] min_l, min_r, sec_l, sec_r;
  logic       adj_out, running;
  logic [2:0] adj_sel;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: time held as plain minute/second integers plus mode flags.
  bit   mRun, mAdj, mPauseQ, mClrQ;
  int   mMin, mSec;
  logic [2:0] mAdjSel;

  typedef struct {
    logic [6:0] in;  // {rst, pause, clr, adj, sel, tick_1hz, tick_adj}
    int         eMin;
    int         eSec;
    logic       eRun;
    logic       eAdj;
    logic [2:0] eSel;
  } vec_t;

  vec_t vecs[14];

  stopwatch_ctrl #(.MIN_MAX(MIN_MAX)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
    .pause_btn(pause_btn), .clr_btn(clr_btn), .adj(adj), .sel(sel),
    .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
    .adj_out(adj_out), .adj_sel(adj_sel), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelStep();
    bit pe, ce;
    int t;
    if (rst) begin
      mRun = 0; mAdj = 0; mMin = 0; mSec = 0; mPauseQ = 1; mClrQ = 1;
    end else begin
      pe = pause_btn && !mPauseQ;
      ce = clr_btn && !mClrQ;
      mPauseQ = pause_btn;
      mClrQ = clr_btn;
      if (ce) begin
        mMin = 0; mSec = 0; mRun = 0;
      end else if (adj) begin
        if (mAdj && tick_adj) begin
          if (sel) mSec = (mSec + 1) % 60;
          else     mMin = (mMin + 1) % (MIN_MAX + 1);
        end
        mAdj = 1; mRun = 0;
      end else if (mAdj) begin
        mAdj = 0;
      end else if (pe) begin
        mRun = !mRun;
      end else if (tick_1hz && mRun) begin
        t = (mMin * 60 + mSec + 1) % ((MIN_MAX + 1) * 60);
        mMin = t / 60;
        mSec = t % 60;
      end
    end
    mAdjSel = mAdj ? (sel ? 3'd1 : 3'd3) : 3'd4;
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    {rst, pause_btn, clr_btn, adj, sel, tick_1hz, tick_adj} = v.in;
    cycle();
  endtask

  task automatic checkOutput(input string name, input int eMin, input int eSec,
                             input logic eRun, input logic eAdj, input logic [2:0] eSel);
    logic [24:0] act, exp;
    act = {min_l, min_r, sec_l, sec_r, running, adj_out, adj_sel};
    exp = {1'b0, 4'(eMin / 10), 1'b0, 4'(eMin % 10), 1'b0, 4'(eSec / 10), 1'b0, 4'(eSec % 10),
           eRun, eAdj, eSel};
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d%0d:%0d%0d run=%0b adj_out=%0b adj_sel=%0d, expected %02d:%02d run=%0b adj_out=%0b adj_sel=%0d",
               name, min_l, min_r, sec_l, sec_r, running, adj_out, adj_sel,
               eMin, eSec, eRun, eAdj, eSel);
    end
  endtask

  task automatic pulseTick1(input int n);
    repeat (n) begin
      tick_1hz = 1; cycle();
      tick_1hz = 0; cycle();
    end
  endtask

  task automatic pulseTickAdj(input int n);
    repeat (n) begin
      tick_adj = 1; cycle();
      tick_adj = 0; cycle();
    end
  endtask

  task automatic doReset();
    rst = 1; cycle();
    rst = 0; cycle();
  endtask

  initial begin
    {rst, pause_btn, clr_btn, adj, sel, tick_1hz, tick_adj} = 7'b0;
    mRun = 0; mAdj = 0; mMin = 0; mSec = 0; mPauseQ = 1; mClrQ = 1; mAdjSel = 3'd4;

    vecs[0]  = '{7'b1000000, 0, 0, 1'b0, 1'b0, 3'd4};
    vecs[1]  = '{7'b0000000, 0, 0, 1'b0, 1'b0, 3'd4};
    vecs[2]  = '{7'b0100000, 0, 0, 1'b1, 1'b0, 3'd4};
    vecs[3]  = '{7'b0100010, 0, 1, 1'b1, 1'b0, 3'd4};
    vecs[4]  = '{7'b0000010, 0, 2, 1'b1, 1'b0, 3'd4};
    vecs[5]  = '{7'b0001010, 0, 2, 1'b0, 1'b1, 3'd3};
    vecs[6]  = '{7'b0001001, 1, 2, 1'b0, 1'b1, 3'd3};
    vecs[7]  = '{7'b0001101, 1, 3, 1'b0, 1'b1, 3'd1};
    vecs[8]  = '{7'b0011100, 0, 0, 1'b0, 1'b1, 3'd1};
    vecs[9]  = '{7'b0010000, 0, 0, 1'b0, 1'b0, 3'd4};
    vecs[10] = '{7'b0000010, 0, 0, 1'b0, 1'b0, 3'd4};
    vecs[11] = '{7'b0000001, 0, 0, 1'b0, 1'b0, 3'd4};
    vecs[12] = '{7'b0100010, 0, 0, 1'b1, 1'b0, 3'd4};
    vecs[13] = '{7'b0000010, 0, 1, 1'b1, 1'b0, 3'd4};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].eMin, vecs[i].eSec,
                  vecs[i].eRun, vecs[i].eAdj, vecs[i].eSel);
    end
    {rst, pause_btn, clr_btn, adj, sel, tick_1hz, tick_adj} = 7'b0;

    // Run from reset and count past the first minute.
    doReset();
    checkOutput("reset", 0, 0, 1'b0, 1'b0, 3'd4);
    pause_btn = 1; cycle(); pause_btn = 0; cycle();
    checkOutput("run_entry", 0, 0, 1'b1, 1'b0, 3'd4);
    pulseTick1(61);
    checkOutput("tick61", 1, 1, 1'b1, 1'b0, 3'd4);

    // Load 59:59 through adjust mode, then one tick wraps to 00:00.
    adj = 1; sel = 0; cycle();
    pulseTickAdj(58);
    sel = 1;
    pulseTickAdj(58);
    checkOutput("preload", 59, 59, 1'b0, 1'b1, 3'd1);
    adj = 0; cycle();
    pause_btn = 1; cycle(); pause_btn = 0; cycle();
    checkOutput("preload_run", 59, 59, 1'b1, 1'b0, 3'd4);
    tick_1hz = 1; cycle(); tick_1hz = 0;
    checkOutput("full_wrap", 0, 0, 1'b1, 1'b0, 3'd4);

    pulseTick1(5);
    checkOutput("run_5s", 0, 5, 1'b1, 1'b0, 3'd4);
    clr_btn = 1; tick_1hz = 1; cycle(); clr_btn = 0; tick_1hz = 0;
    checkOutput("clr_beats_tick", 0, 0, 1'b0, 1'b0, 3'd4);
    cycle();
    checkOutput("clr_stays_paused", 0, 0, 1'b0, 1'b0, 3'd4);

    // Seconds adjust wraps 59->00 without touching minutes.
    adj = 1; sel = 1; cycle();
    pulseTickAdj(58);
    checkOutput("adj_58", 0, 58, 1'b0, 1'b1, 3'd1);
    pulseTickAdj(3);
    checkOutput("adj_sec_wrap", 0, 1, 1'b0, 1'b1, 3'd1);
    adj = 0; cycle();
    checkOutput("adj_exit", 0, 1, 1'b0, 1'b0, 3'd4);

    // Pause edge and 1 Hz ticks inside adjust have no effect, even after leaving.
    adj = 1; cycle();
    pause_btn = 1; cycle(); pause_btn = 0;
    pulseTick1(10);
    checkOutput("adj_ignores", 0, 1, 1'b0, 1'b1, 3'd1);
    adj = 0; cycle();
    checkOutput("adj_no_resume", 0, 1, 1'b0, 1'b0, 3'd4);
    cycle();
    checkOutput("adj_no_resume2", 0, 1, 1'b0, 1'b0, 3'd4);

    // Button held through reset must not fire until released and pressed again.
    pause_btn = 1; rst = 1; cycle(); rst = 0; cycle(); cycle();
    checkOutput("held_no_run", 0, 0, 1'b0, 1'b0, 3'd4);
    pause_btn = 0; cycle();
    checkOutput("released", 0, 0, 1'b0, 1'b0, 3'd4);
    pause_btn = 1; cycle(); pause_btn = 0;
    checkOutput("rerise_run", 0, 0, 1'b1, 1'b0, 3'd4);

    // Reset mid-count wins over a simultaneous tick.
    pulseTick1(3);
    checkOutput("count_3", 0, 3, 1'b1, 1'b0, 3'd4);
    rst = 1; tick_1hz = 1; cycle(); rst = 0; tick_1hz = 0;
    checkOutput("rst_mid", 0, 0, 1'b0, 1'b0, 3'd4);

    doReset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0)  pause_btn = ~pause_btn;
      if ($urandom_range(0, 29) == 0) clr_btn = ~clr_btn;
      if ($urandom_range(0, 24) == 0) adj = ~adj;
      if ($urandom_range(0, 5) == 0)  sel = ~sel;
      tick_1hz = ($urandom_range(0, 1) == 0);
      tick_adj = ($urandom_range(0, 1) == 0);
      cycle();
      checkOutput($sformatf("random%0d", i), mMin, mSec, mRun, mAdj, mAdjSel);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
